// File: rtl/picoblaze_io_hub_if.sv
// Core-side bus plus datapath byte ports and start/finish channels
// shared by picoblaze_io_hub and whoever drives it.
interface picoblaze_io_hub_if #(
  parameter int NUM_OUT = 2,
  parameter int NUM_IN  = 2,
  parameter int NUM_CH  = 2
);
  logic [7:0]           port_id;
  logic [7:0]           out_port;
  logic                 write_strobe;
  logic [7:0]           in_port;
  logic                 interrupt;
  logic                 interrupt_ack;
  logic [8*NUM_IN-1:0]  in_data;
  logic [8*NUM_OUT-1:0] out_data;
  logic [NUM_CH-1:0]    fsm_start;
  logic [NUM_CH-1:0]    fsm_finish;

  modport master (
    output port_id, out_port, write_strobe, interrupt_ack,
    output in_data, fsm_finish,
    input  in_port, interrupt, out_data, fsm_start
  );

  modport slave (
    input  port_id, out_port, write_strobe, interrupt_ack,
    input  in_data, fsm_finish,
    output in_port, interrupt, out_data, fsm_start
  );
endinterface

// File: rtl/picoblaze_io_hub.sv
// I/O and interrupt hub: output byte regs, input byte mux, start/finish
// channels with pending/enable/busy and an ack-cleared interrupt.
module picoblaze_io_hub #(
  parameter int NUM_OUT    = 2,
  parameter int NUM_IN     = 2,
  parameter int NUM_CH     = 2,
  parameter int START_MODE = 0
) (
  input logic               clk,
  input logic               reset,
  picoblaze_io_hub_if.slave bus
);

  logic [7:0]        out_q [NUM_OUT];
  logic [7:0]        out_d [NUM_OUT];
  logic [7:0]        in_port_q, in_port_d;
  logic [NUM_CH-1:0] start_q, start_d;
  logic [NUM_CH-1:0] finish_q;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] en_q, en_d;
  logic [NUM_CH-1:0] busy_q, busy_d;
  logic              irq_q, irq_d;

  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] wbits;
  logic              sel_start, sel_en, sel_clr;
  logic              irq_event;

  always_comb begin
    wbits     = bus.out_port[NUM_CH-1:0];
    sel_start = bus.write_strobe && (bus.port_id == 8'h40);
    sel_en    = bus.write_strobe && (bus.port_id == 8'h22);
    sel_clr   = bus.write_strobe && (bus.port_id == 8'h23);
    rise      = bus.fsm_finish & ~finish_q;

    en_d = sel_en ? wbits : en_q;

    // rise sets after the W1C clear so a same-cycle edge is not lost
    pend_d = pend_q & ~(sel_clr ? wbits : '0);
    pend_d = pend_d | rise;

    busy_d = (busy_q & ~rise) | (sel_start ? wbits : '0);

    if (START_MODE == 0) start_d = sel_start ? wbits : '0;
    else                 start_d = sel_start ? wbits : start_q;

    irq_event = |(rise & en_d);
    if (sel_en && |(pend_q & wbits & ~en_q)) irq_event = 1'b1;
    irq_d = irq_event | (irq_q & ~bus.interrupt_ack);

    for (int k = 0; k < NUM_OUT; k++) begin
      out_d[k] = out_q[k];
      if (bus.write_strobe && bus.port_id == 8'(128 + k))
        out_d[k] = bus.out_port;
    end

    in_port_d = 8'h00;
    for (int k = 0; k < NUM_IN; k++) begin
      if (bus.port_id == 8'(k)) in_port_d = bus.in_data[8*k +: 8];
    end
    case (bus.port_id)
      8'h20:   in_port_d = 8'(bus.fsm_finish);
      8'h21:   in_port_d = 8'(pend_q);
      8'h22:   in_port_d = 8'(en_q);
      8'h24:   in_port_d = 8'(busy_q);
      default: ;
    endcase
  end

  // finish_q resets high so a finish held across reset is not an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q     <= '{default: '0};
      in_port_q <= '0;
      start_q   <= '0;
      finish_q  <= '1;
      pend_q    <= '0;
      en_q      <= '0;
      busy_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      out_q     <= out_d;
      in_port_q <= in_port_d;
      start_q   <= start_d;
      finish_q  <= bus.fsm_finish;
      pend_q    <= pend_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
      irq_q     <= irq_d;
    end
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
    assign bus.out_data[8*g +: 8] = out_q[g];
  end

  assign bus.in_port   = in_port_q;
  assign bus.interrupt = irq_q;
  assign bus.fsm_start = start_q;

endmodule
